mem_bus_arbiter: RTL and testbench

- Shares the single 256-bit memory port (RAM ready/done handshake) between two requesters: port 0 = instruction cache, port 1 = data cache.
- Sits between the cache layer inside the CPU and the CPU memory pins.
- Arbitrates round-robin and sequences each transaction on the memory handshake.
- Returns read data and a one-cycle completion pulse to the winning requester.

---
 rtl/mem_bus_arbiter_pkg.sv | 10 +
 rtl/mem_bus_arbiter_rr_arbiter_2.sv | 29 ++
 rtl/mem_bus_arbiter.sv | 114 +++++++++++
 tb/tb_mem_bus_arbiter.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and default widths for the memory bus arbitration stages.
package mem_bus_arbiter_pkg;

  localparam int unsigned MEM_LINE_WIDTH = 256;
  localparam int unsigned MEM_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_RELEASE} arb_state_e;
  typedef enum logic {MEM_OP_READ, MEM_OP_WRITE} mem_op_e;

endpackage

// File: rtl/mem_bus_arbiter_rr_arbiter_2.sv
// Two-way round-robin select: on a tie the port that was not served last wins.
module rr_arbiter_2 (
  input  logic [1:0] request,
  input  logic       last,
  output logic [1:0] grant,
  output logic       id
);

  always_comb begin
    grant = 2'b00;
    id    = 1'b0;
    case (request)
      2'b01: begin
        grant = 2'b01;
        id    = 1'b0;
      end
      2'b10: begin
        grant = 2'b10;
        id    = 1'b1;
      end
      2'b11: begin
        grant = last ? 2'b01 : 2'b10;
        id    = ~last;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one cache-line memory port between the instruction and data caches,
// sequencing each transaction over the RAM ready/done handshake.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = MEM_ADDR_WIDTH,
  parameter int unsigned LINE_WIDTH     = MEM_LINE_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic [1:0]                 i_req_read,
  input  logic [1:0]                 i_req_write,
  input  logic [1:0][ADDR_WIDTH-1:0] i_req_address,
  input  logic [1:0][LINE_WIDTH-1:0] i_req_wdata,
  output logic [LINE_WIDTH-1:0]      o_req_rdata,
  output logic [1:0]                 o_req_done,
  output logic [1:0]                 o_req_grant,
  output logic                       o_busy,
  output logic                       o_timeout,
  input  logic                       i_mem_ready,
  input  logic                       i_mem_done,
  inout  logic [LINE_WIDTH-1:0]      io_mem_data,
  output logic [ADDR_WIDTH-1:0]      o_mem_address,
  output logic                       o_mem_read,
  output logic                       o_mem_write
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  arb_state_e            state;
  mem_op_e               op;
  logic                  id;
  logic                  last;
  logic                  drive;
  logic [LINE_WIDTH-1:0] wdata;
  logic [CNT_W-1:0]      count;
  logic [1:0]            eligible;
  logic [1:0]            pick;
  logic                  pick_id;

  assign eligible = i_req_read | i_req_write;

  rr_arbiter_2 u_rr (
    .request (eligible),
    .last    (last),
    .grant   (pick),
    .id      (pick_id)
  );

  assign io_mem_data = drive ? wdata : 'z;
  assign o_busy      = (state != ARB_IDLE);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state         <= ARB_IDLE;
      op            <= MEM_OP_READ;
      id            <= 1'b0;
      last          <= 1'b1;
      drive         <= 1'b0;
      wdata         <= '0;
      count         <= '0;
      o_req_rdata   <= '0;
      o_req_done    <= '0;
      o_req_grant   <= '0;
      o_timeout     <= 1'b0;
      o_mem_address <= '0;
      o_mem_read    <= 1'b0;
      o_mem_write   <= 1'b0;
    end else begin
      o_req_done <= '0;
      unique case (state)
        ARB_IDLE: begin
          if (|eligible && i_mem_ready) begin
            // write wins when a port raises both read and write
            id            <= pick_id;
            o_mem_address <= i_req_address[pick_id];
            wdata         <= i_req_wdata[pick_id];
            op            <= i_req_write[pick_id] ? MEM_OP_WRITE : MEM_OP_READ;
            o_mem_read    <= ~i_req_write[pick_id];
            o_mem_write   <= i_req_write[pick_id];
            drive         <= i_req_write[pick_id];
            o_req_grant   <= pick;
            count         <= '0;
            state         <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          if (i_mem_done || count == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            if (i_mem_done) begin
              if (op == MEM_OP_READ) o_req_rdata <= io_mem_data;
            end else begin
              o_timeout <= 1'b1;
            end
            o_req_done  <= id ? 2'b10 : 2'b01;
            o_mem_read  <= 1'b0;
            o_mem_write <= 1'b0;
            o_req_grant <= '0;
            drive       <= 1'b0;
            last        <= id;
            state       <= ARB_RELEASE;
          end else begin
            count <= count + 1'b1;
          end
        end
        ARB_RELEASE: begin
          if (!i_mem_done) state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: behavioural RAM on the handshake plus a line-level
// scoreboard of expected memory contents, winners and returned data.
module tb_mem_bus_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] req_read, req_write;
  logic [1:0][AW-1:0] req_addr;
  logic [1:0][LW-1:0] req_wdata;
  logic [LW-1:0] req_rdata;
  logic [1:0] req_done, req_grant;
  logic busy, timeout;
  logic mem_ready;
  logic ram_done;
  wire  [LW-1:0] mem_data;
  logic [AW-1:0] mem_addr;
  logic mem_rd, mem_wr;

  logic ram_drive, ram_enable;
  logic [LW-1:0] ram_data;
  int ram_wait;
  logic [LW-1:0] ram_mem [logic [AW-1:0]];
  logic [LW-1:0] ref_mem [logic [AW-1:0]];
  logic [LW-1:0] ref_rdata;

  int tests = 0;
  int fails = 0;

  assign mem_data = ram_drive ? ram_data : 'z;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .TIMEOUT_CYCLES(TO)) dut (
    .i_clock       (clk),
    .i_reset       (rst_n),
    .i_req_read    (req_read),
    .i_req_write   (req_write),
    .i_req_address (req_addr),
    .i_req_wdata   (req_wdata),
    .o_req_rdata   (req_rdata),
    .o_req_done    (req_done),
    .o_req_grant   (req_grant),
    .o_busy        (busy),
    .o_timeout     (timeout),
    .i_mem_ready   (mem_ready),
    .i_mem_done    (ram_done),
    .io_mem_data   (mem_data),
    .o_mem_address (mem_addr),
    .o_mem_read    (mem_rd),
    .o_mem_write   (mem_wr)
  );

  // RAM: random 0-3 cycle latency, done held exactly one cycle
  always @(posedge clk) begin
    #1;
    if (ram_done) begin
      ram_done  = 1'b0;
      ram_drive = 1'b0;
    end else if (ram_enable && rst_n && (mem_rd || mem_wr)) begin
      if (ram_wait == 0) begin
        ram_done = 1'b1;
        if (mem_rd) begin
          ram_data  = ram_mem.exists(mem_addr) ? ram_mem[mem_addr] : '0;
          ram_drive = 1'b1;
        end else begin
          ram_mem[mem_addr] = mem_data;
        end
        ram_wait = $urandom_range(0, 3);
      end else begin
        ram_wait--;
      end
    end
  end

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic wait_strobe(input int budget, output logic ok, output int n);
    ok = 1'b0;
    n = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      n++;
      if (mem_rd || mem_wr) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (req_done != 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, req_grant, req_done, timeout, mem_rd, mem_wr} !== 8'h00) begin
      fails++;
      $display("FAIL reset_ctrl busy=%b grant=%b done=%b timeout=%b rd=%b wr=%b required all 0",
               busy, req_grant, req_done, timeout, mem_rd, mem_wr);
    end
    tests++;
    if (req_rdata !== '0 || mem_addr !== '0) begin
      fails++;
      $display("FAIL reset_data rdata=%h addr=%h required 0", req_rdata, mem_addr);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ref_rdata = '0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || mem_rd !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle busy=%b rd=%b required 0 0", busy, mem_rd);
    end
  endtask

  task automatic test_single_read();
    logic [LW-1:0] line;
    logic ok;
    int n;
    line = {32{8'hA5}};
    ram_mem[32'h40] = line;
    ref_mem[32'h40] = line;
    req_addr[0] = 32'h40;
    req_read = 2'b01;
    wait_strobe(10, ok, n);
    tests++;
    if (!ok || n != 1 || mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 32'h40 || req_grant !== 2'b01) begin
      fails++;
      $display("FAIL read_issue ok=%b n=%0d rd=%b wr=%b addr=%h grant=%b required 1 1 1 0 00000040 01",
               ok, n, mem_rd, mem_wr, mem_addr, req_grant);
    end
    wait_done(20, ok);
    tests++;
    if (!ok || req_done !== 2'b01 || req_rdata !== line || mem_rd !== 1'b0 || req_grant !== 2'b00) begin
      fails++;
      $display("FAIL read_done ok=%b done=%b rd=%b grant=%b rdata=%h required done=01 rd=0 grant=00 rdata=%h",
               ok, req_done, mem_rd, req_grant, req_rdata, line);
    end
    ref_rdata = line;
    req_read = 2'b00;
    @(negedge clk);
    tests++;
    if (req_done !== 2'b00 || mem_rd !== 1'b0) begin
      fails++;
      $display("FAIL read_pulse done=%b rd=%b required 00 0", req_done, mem_rd);
    end
  endtask

  task automatic test_single_write();
    logic [LW-1:0] w;
    logic ok;
    int n;
    w = LW'(16'h1234);
    req_addr[1] = 32'h80;
    req_wdata[1] = w;
    req_write = 2'b10;
    wait_strobe(10, ok, n);
    tests++;
    if (!ok || mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 32'h80 || req_grant !== 2'b10) begin
      fails++;
      $display("FAIL write_issue ok=%b wr=%b rd=%b addr=%h grant=%b required 1 1 0 00000080 10",
               ok, mem_wr, mem_rd, mem_addr, req_grant);
    end
    tests++;
    if (mem_data !== w) begin
      fails++;
      $display("FAIL write_bus data=%h required %h", mem_data, w);
    end
    wait_done(20, ok);
    tests++;
    if (!ok || req_done !== 2'b10 || mem_wr !== 1'b0 || req_rdata !== ref_rdata) begin
      fails++;
      $display("FAIL write_done ok=%b done=%b wr=%b rdata=%h required done=10 wr=0 rdata=%h",
               ok, req_done, mem_wr, req_rdata, ref_rdata);
    end
    ref_mem[32'h80] = w;
    req_write = 2'b00;
    @(negedge clk);
    req_addr[0] = 32'h80;
    req_read = 2'b01;
    wait_strobe(10, ok, n);
    tests++;
    if (!ok || mem_rd !== 1'b1 || mem_addr !== 32'h80 || req_grant !== 2'b01) begin
      fails++;
      $display("FAIL readback_issue ok=%b rd=%b addr=%h grant=%b required 1 1 00000080 01",
               ok, mem_rd, mem_addr, req_grant);
    end
    wait_done(20, ok);
    tests++;
    if (!ok || req_done !== 2'b01 || req_rdata !== ref_mem[32'h80]) begin
      fails++;
      $display("FAIL readback_data ok=%b done=%b rdata=%h required done=01 rdata=%h",
               ok, req_done, req_rdata, ref_mem[32'h80]);
    end
    ref_rdata = ref_mem[32'h80];
    req_read = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_contention();
    logic [AW-1:0] pool [4];
    logic [AW-1:0] cur [2];
    logic [1:0] exp_hot;
    logic ok;
    int n;
    int served_last;
    int win;
    pool = '{32'h00, 32'h20, 32'h40, 32'h60};
    foreach (pool[i]) begin
      ref_mem[pool[i]] = rand_line();
      ram_mem[pool[i]] = ref_mem[pool[i]];
    end
    rst_n = 1'b0;
    cur[0] = 32'h00;
    cur[1] = 32'h20;
    req_addr[0] = cur[0];
    req_addr[1] = cur[1];
    req_read = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    ref_rdata = '0;
    served_last = 1;
    for (int t = 0; t < 6; t++) begin
      // both ports always pending, so the winner is the port not served last
      win = 1 - served_last;
      exp_hot = (win == 1) ? 2'b10 : 2'b01;
      wait_strobe(10, ok, n);
      tests++;
      if (!ok || n != 1 || req_grant !== exp_hot || mem_addr !== cur[win] || mem_rd !== 1'b1) begin
        fails++;
        $display("FAIL contention_issue t=%0d ok=%b n=%0d grant=%b addr=%h rd=%b required n=1 grant=%b addr=%h rd=1",
                 t, ok, n, req_grant, mem_addr, mem_rd, exp_hot, cur[win]);
      end
      wait_done(20, ok);
      tests++;
      if (!ok || req_done !== exp_hot || req_rdata !== ref_mem[cur[win]] || mem_rd !== 1'b0) begin
        fails++;
        $display("FAIL contention_done t=%0d ok=%b done=%b rd=%b rdata=%h required done=%b rd=0 rdata=%h",
                 t, ok, req_done, mem_rd, req_rdata, exp_hot, ref_mem[cur[win]]);
      end
      ref_rdata = ref_mem[cur[win]];
      served_last = win;
      req_read[win] = 1'b0;
      @(negedge clk);
      tests++;
      if ((mem_rd | mem_wr) !== 1'b0 || req_done !== 2'b00 || busy !== 1'b0) begin
        fails++;
        $display("FAIL contention_gap t=%0d rd=%b wr=%b done=%b busy=%b required 0 0 00 0",
                 t, mem_rd, mem_wr, req_done, busy);
      end
      if (t < 5) begin
        cur[win] = pool[$urandom_range(0, 3)];
        req_addr[win] = cur[win];
        req_read[win] = 1'b1;
      end else begin
        req_read = 2'b00;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_not_ready();
    logic ok;
    int n;
    mem_ready = 1'b0;
    req_addr[1] = 32'h40;
    req_read = 2'b10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if ((mem_rd | mem_wr) !== 1'b0 || req_grant !== 2'b00 || busy !== 1'b0) begin
        fails++;
        $display("FAIL not_ready_hold i=%0d rd=%b wr=%b grant=%b busy=%b required 0 0 00 0",
                 i, mem_rd, mem_wr, req_grant, busy);
      end
    end
    mem_ready = 1'b1;
    wait_strobe(10, ok, n);
    tests++;
    if (!ok || n != 1 || req_grant !== 2'b10 || mem_addr !== 32'h40) begin
      fails++;
      $display("FAIL not_ready_issue ok=%b n=%0d grant=%b addr=%h required n=1 grant=10 addr=00000040",
               ok, n, req_grant, mem_addr);
    end
    wait_done(20, ok);
    tests++;
    if (!ok || req_done !== 2'b10 || req_rdata !== ref_mem[32'h40]) begin
      fails++;
      $display("FAIL not_ready_done ok=%b done=%b rdata=%h required done=10 rdata=%h",
               ok, req_done, req_rdata, ref_mem[32'h40]);
    end
    ref_rdata = ref_mem[32'h40];
    req_read = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    logic ok;
    int n;
    int cycles;
    tests++;
    if (timeout !== 1'b0) begin
      fails++;
      $display("FAIL timeout_pre timeout=%b required 0", timeout);
    end
    ram_enable = 1'b0;
    req_addr[0] = 32'h20;
    req_read = 2'b01;
    wait_strobe(10, ok, n);
    cycles = ok ? 1 : 0;
    for (int i = 0; i < 40 && ok; i++) begin
      @(negedge clk);
      if (mem_rd || mem_wr) cycles++;
      else break;
    end
    tests++;
    if (cycles != TO) begin
      fails++;
      $display("FAIL timeout_cycles access_cycles=%0d required %0d", cycles, TO);
    end
    tests++;
    if (req_done !== 2'b01 || timeout !== 1'b1 || req_rdata !== ref_rdata || req_grant !== 2'b00) begin
      fails++;
      $display("FAIL timeout_abort done=%b timeout=%b grant=%b rdata=%h required 01 1 00 rdata=%h",
               req_done, timeout, req_grant, req_rdata, ref_rdata);
    end
    req_read = 2'b00;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || timeout !== 1'b1 || req_done !== 2'b00) begin
      fails++;
      $display("FAIL timeout_sticky busy=%b timeout=%b done=%b required 0 1 00", busy, timeout, req_done);
    end
    ram_enable = 1'b1;
  endtask

  task automatic test_reset_mid_write();
    logic [LW-1:0] w;
    logic ok;
    int n;
    ram_enable = 1'b0;
    w = rand_line();
    req_addr[1] = 32'h60;
    req_wdata[1] = w;
    req_write = 2'b10;
    wait_strobe(10, ok, n);
    tests++;
    if (!ok || mem_wr !== 1'b1 || mem_data !== w) begin
      fails++;
      $display("FAIL midwrite_issue ok=%b wr=%b data=%h required wr=1 data=%h", ok, mem_wr, mem_data, w);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({mem_wr, mem_rd, busy, req_grant, req_done, timeout} !== 8'h00) begin
      fails++;
      $display("FAIL midwrite_reset wr=%b rd=%b busy=%b grant=%b done=%b timeout=%b required all 0",
               mem_wr, mem_rd, busy, req_grant, req_done, timeout);
    end
    ram_data = ~w;
    ram_drive = 1'b1;
    #1;
    tests++;
    if (mem_data !== ~w) begin
      fails++;
      $display("FAIL midwrite_bus_released data=%h required %h", mem_data, ~w);
    end
    ram_drive = 1'b0;
    req_write = 2'b00;
    ref_rdata = '0;
    req_addr[0] = 32'h00;
    req_addr[1] = 32'h20;
    req_read = 2'b11;
    ram_enable = 1'b1;
    @(negedge clk);
    tests++;
    if (req_done !== 2'b00 || mem_wr !== 1'b0) begin
      fails++;
      $display("FAIL midwrite_no_done done=%b wr=%b required 00 0", req_done, mem_wr);
    end
    rst_n = 1'b1;
    wait_strobe(10, ok, n);
    tests++;
    if (!ok || n != 1 || req_grant !== 2'b01 || mem_addr !== 32'h00) begin
      fails++;
      $display("FAIL post_reset_winner ok=%b n=%0d grant=%b addr=%h required n=1 grant=01 addr=00000000",
               ok, n, req_grant, mem_addr);
    end
    wait_done(20, ok);
    tests++;
    if (!ok || req_done !== 2'b01 || req_rdata !== ref_mem[32'h00]) begin
      fails++;
      $display("FAIL post_reset_data ok=%b done=%b rdata=%h required done=01 rdata=%h",
               ok, req_done, req_rdata, ref_mem[32'h00]);
    end
    req_read = 2'b00;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    req_read   = 2'b00;
    req_write  = 2'b00;
    req_addr   = '0;
    req_wdata  = '0;
    mem_ready  = 1'b1;
    ram_enable = 1'b1;
    ram_drive  = 1'b0;
    ram_done   = 1'b0;
    ram_data   = '0;
    ram_wait   = 0;
    ref_rdata  = '0;
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_not_ready();
    test_timeout();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
